// File: rtl/soafa_pkg.sv
// Shared types and defaults for the SOAFA macro access sequencer.
// Imported by the controller and its row decoder.
package soafa_pkg;

  localparam int DEF_ROWS = 128;
  localparam int DEF_COLS = 64;

  typedef enum logic {
    OP_WRITE = 1'b0,
    OP_COMP  = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    COMP  = 2'd2,
    RESP  = 2'd3
  } state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/soafa_row_decode.sv
// Row index to one-hot word-line decoder with out-of-range flag.
// Indices at or beyond ROWS yield an all-zero word-line vector.
module soafa_row_decode
  import soafa_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  localparam int RW  = idx_w(ROWS)
) (
  input  logic [RW-1:0]   row,
  output logic [ROWS-1:0] onehot,
  output logic            oor
);

  logic [RW:0] row_x;

  assign row_x = {1'b0, row};

  always_comb begin
    oor    = (row_x >= (RW+1)'(ROWS));
    onehot = '0;
    for (int i = 0; i < ROWS; i++) begin
      onehot[i] = (row_x == (RW+1)'(i));
    end
  end

endmodule

// File: rtl/soafa_macro_ctrl.sv
// Host-side access sequencer for the SOAFA compute-in-memory macro.
// One WRITE or COMPUTE per request handshake, one response per request.
module soafa_macro_ctrl
  import soafa_pkg::*;
#(
  parameter int ROWS      = DEF_ROWS,
  parameter int COLS      = DEF_COLS,
  parameter int WR_CYCLES = 2,
  parameter int COMP_LAT  = 3,
  localparam int RW       = idx_w(ROWS)
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_op,
  input  logic [RW-1:0]   req_row,
  input  logic [COLS-1:0] req_data,
  input  logic            req_addr,
  input  logic [ROWS-1:0] req_inb,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [COLS-1:0] rsp_data,
  output logic            rsp_err,
  output logic            WE,
  output logic [COLS-1:0] BL,
  output logic [COLS-1:0] BLB,
  output logic            Addr,
  output logic [ROWS-1:0] WL,
  output logic [ROWS-1:0] In_B,
  output logic            wb,
  input  logic [COLS-1:0] DOut
);

  localparam int CW = $clog2(max2(WR_CYCLES, COMP_LAT) + 1);

  state_e          state;
  logic [CW-1:0]   cnt;
  logic [RW-1:0]   row_q;
  logic [COLS-1:0] data_q;
  logic            addr_q;
  logic [ROWS-1:0] inb_q;
  logic [ROWS-1:0] row_hot;
  logic            row_oor;

  soafa_row_decode #(
    .ROWS (ROWS)
  ) u_row_decode (
    .row    (row_q),
    .onehot (row_hot),
    .oor    (row_oor)
  );

  assign req_ready = (state == IDLE) && Rst;

  // Pins default to idle every edge; only the active drive phase overrides.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state     <= IDLE;
      cnt       <= '0;
      row_q     <= '0;
      data_q    <= '0;
      addr_q    <= 1'b0;
      inb_q     <= '0;
      WE        <= 1'b0;
      BL        <= '0;
      BLB       <= '0;
      Addr      <= 1'b0;
      WL        <= '0;
      In_B      <= '0;
      wb        <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      WE   <= 1'b0;
      BL   <= '0;
      BLB  <= '0;
      Addr <= 1'b0;
      WL   <= '0;
      In_B <= '0;
      wb   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            row_q  <= req_row;
            data_q <= req_data;
            addr_q <= req_addr;
            inb_q  <= req_inb;
            cnt    <= '0;
            state  <= (req_op == OP_COMP) ? COMP : WRITE;
          end
        end
        WRITE: begin
          if (cnt == CW'(WR_CYCLES)) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_data  <= '0;
            rsp_err   <= row_oor;
          end else begin
            cnt <= cnt + 1'b1;
            WE  <= 1'b1;
            BL  <= data_q;
            BLB <= ~data_q;
            WL  <= row_hot;
          end
        end
        COMP: begin
          if (cnt == CW'(COMP_LAT)) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_data  <= DOut;
            rsp_err   <= 1'b0;
          end else begin
            cnt  <= cnt + 1'b1;
            wb   <= 1'b1;
            Addr <= addr_q;
            WL   <= '1;
            In_B <= inb_q;
            BL   <= '1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_bl_blb: assert property (
    @(posedge Clk) disable iff (!Rst)
    WE |-> ~|(BL & BLB)
  );

  a_rsp_hold: assert property (
    @(posedge Clk) disable iff (!Rst)
    (rsp_valid && !rsp_ready) |=>
      (rsp_valid && $stable(rsp_data) && $stable(rsp_err))
  );

endmodule

// File: tb/tb_soafa_macro_ctrl.sv
// Randomized self-checking bench for soafa_macro_ctrl.
// Second instance with ROWS=100 covers out-of-range write rows.
module tb_soafa_macro_ctrl;
  import soafa_pkg::*;

  typedef logic [386:0] pins_t;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  always #5 Clk = ~Clk;

  logic         req_valid, req_ready, req_op, req_addr;
  logic [6:0]   req_row;
  logic [63:0]  req_data;
  logic [127:0] req_inb;
  logic         rsp_valid, rsp_ready, rsp_err;
  logic [63:0]  rsp_data;
  logic         WE, Addr, wb;
  logic [63:0]  BL, BLB, DOut;
  logic [127:0] WL, In_B;

  logic         b_req_valid, b_req_ready, b_req_op, b_req_addr;
  logic [6:0]   b_req_row;
  logic [63:0]  b_req_data;
  logic [99:0]  b_req_inb;
  logic         b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [63:0]  b_rsp_data;
  logic         b_WE, b_Addr, b_wb;
  logic [63:0]  b_BL, b_BLB, b_DOut;
  logic [99:0]  b_WL, b_In_B;

  int checks = 0;
  int errors = 0;

  soafa_macro_ctrl dut (
    .Clk(Clk), .Rst(Rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_row(req_row),
    .req_data(req_data), .req_addr(req_addr),
    .req_inb(req_inb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .WE(WE), .BL(BL), .BLB(BLB), .Addr(Addr),
    .WL(WL), .In_B(In_B), .wb(wb), .DOut(DOut)
  );

  soafa_macro_ctrl #(.ROWS(100)) dut2 (
    .Clk(Clk), .Rst(Rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_op(b_req_op), .req_row(b_req_row),
    .req_data(b_req_data), .req_addr(b_req_addr),
    .req_inb(b_req_inb),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_data(b_rsp_data), .rsp_err(b_rsp_err),
    .WE(b_WE), .BL(b_BL), .BLB(b_BLB), .Addr(b_Addr),
    .WL(b_WL), .In_B(b_In_B), .wb(b_wb), .DOut(b_DOut)
  );

  function automatic pins_t pins_now();
    return {WE, wb, Addr, BL, BLB, WL, In_B};
  endfunction

  function automatic logic [63:0] junk64();
    return {$urandom, $urandom};
  endfunction

  task automatic scramble_req();
    req_op   = 1'($urandom);
    req_row  = 7'($urandom);
    req_data = junk64();
    req_addr = 1'($urandom);
    req_inb  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // One full transaction checked cycle by cycle against the pin model.
  task automatic do_req(input bit op, input logic [6:0] row,
                        input logic [63:0] data, input bit addr,
                        input logic [127:0] inb, input logic [63:0] dv,
                        input int hold, input bit keep_valid);
    int    n;
    pins_t exp;
    logic [63:0] exp_data;
    n = op ? 3 : 2;
    exp_data = op ? dv : 64'h0;
    exp = {~op, op, op & addr,
           op ? {64{1'b1}} : data,
           op ? 64'h0 : ~data,
           op ? {128{1'b1}} : (128'(1) << row),
           op ? inb : 128'h0};
    req_valid = 1'b1;
    req_op    = op;
    req_row   = row;
    req_data  = data;
    req_addr  = addr;
    req_inb   = inb;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_ready got %b want 1", req_ready);
    end
    @(posedge Clk);
    @(negedge Clk);
    req_valid = keep_valid;
    scramble_req();
    DOut = junk64();
    checks++;
    if (pins_now() !== '0 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL start_idle pins %h vld %b rdy %b want 0",
               pins_now(), rsp_valid, req_ready);
    end
    for (int k = 1; k <= n; k++) begin
      @(negedge Clk);
      DOut = (k == n) ? dv : junk64();
      checks++;
      if (pins_now() !== exp || rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL drive_c%0d pins %h vld %b want %h vld 0",
                 k, pins_now(), rsp_valid, exp);
      end
    end
    @(negedge Clk);
    DOut = junk64();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== exp_data || rsp_err !== 1'b0
        || pins_now() !== '0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL resp vld %b data %h err %b pins %h rdy %b want 1 %h 0 0 0",
               rsp_valid, rsp_data, rsp_err, pins_now(), req_ready, exp_data);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge Clk);
      DOut = junk64();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== exp_data || rsp_err !== 1'b0
          || pins_now() !== '0 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d vld %b data %h pins %h rdy %b want 1 %h 0 0",
                 h, rsp_valid, rsp_data, pins_now(), req_ready, exp_data);
      end
    end
    rsp_ready = 1'b1;
    @(negedge Clk);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_hs vld %b err %b rdy %b want 0 0 1",
               rsp_valid, rsp_err, req_ready);
    end
  endtask

  task automatic test_reset();
    req_valid = 1'b1;
    scramble_req();
    repeat (2) @(negedge Clk);
    checks++;
    if (pins_now() !== '0 || rsp_valid !== 1'b0 || rsp_data !== 64'h0
        || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset pins %h vld %b data %h err %b rdy %b want all 0",
               pins_now(), rsp_valid, rsp_data, rsp_err, req_ready);
    end
    req_valid = 1'b0;
    Rst = 1'b1;
    @(negedge Clk);
    checks++;
    if (req_ready !== 1'b1 || pins_now() !== '0) begin
      errors++;
      $display("FAIL reset_release rdy %b pins %h want 1 0",
               req_ready, pins_now());
    end
  endtask

  task automatic test_write();
    do_req(1'b0, 7'd5, 64'hA5A5_0000_FFFF_1234, 1'b0, 128'h0,
           64'h0, 0, 1'b0);
  endtask

  task automatic test_compute();
    do_req(1'b1, 7'd0, 64'h0, 1'b1,
           128'h80FF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_F000,
           64'hDEAD_BEEF_0123_4567, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    do_req(1'b1, 7'd3, junk64(), 1'b0, {$urandom, $urandom, $urandom, $urandom},
           64'h0123_4567_89AB_CDEF, 10, 1'b0);
    do_req(1'b0, 7'd127, junk64(), 1'b0, 128'h0, 64'h0, 10, 1'b0);
  endtask

  task automatic test_oor();
    int rlist[2] = '{120, 99};
    for (int i = 0; i < 2; i++) begin
      logic [99:0] exp_wl;
      logic [63:0] d;
      d = junk64();
      exp_wl = (rlist[i] < 100) ? (100'(1) << rlist[i]) : 100'h0;
      b_req_valid = 1'b1;
      b_req_row   = 7'(rlist[i]);
      b_req_data  = d;
      checks++;
      if (b_req_ready !== 1'b1) begin
        errors++;
        $display("FAIL oor_ready got %b want 1", b_req_ready);
      end
      @(posedge Clk);
      @(negedge Clk);
      b_req_valid = 1'b0;
      for (int k = 1; k <= 2; k++) begin
        @(negedge Clk);
        checks++;
        if (b_WE !== 1'b1 || b_WL !== exp_wl || b_BL !== d || b_BLB !== ~d
            || b_wb !== 1'b0 || b_In_B !== 100'h0) begin
          errors++;
          $display("FAIL oor_drive row %0d we %b wl %h bl %h want 1 %h %h",
                   rlist[i], b_WE, b_WL, b_BL, exp_wl, d);
        end
      end
      @(negedge Clk);
      checks++;
      if (b_rsp_valid !== 1'b1 || b_rsp_err !== (rlist[i] >= 100)
          || b_rsp_data !== 64'h0 || b_WE !== 1'b0 || b_WL !== 100'h0) begin
        errors++;
        $display("FAIL oor_resp row %0d vld %b err %b data %h want 1 %b 0",
                 rlist[i], b_rsp_valid, b_rsp_err, b_rsp_data,
                 rlist[i] >= 100);
      end
      b_rsp_ready = 1'b1;
      @(negedge Clk);
      b_rsp_ready = 1'b0;
      checks++;
      if (b_rsp_valid !== 1'b0 || b_rsp_err !== 1'b0 || b_req_ready !== 1'b1) begin
        errors++;
        $display("FAIL oor_post vld %b err %b rdy %b want 0 0 1",
                 b_rsp_valid, b_rsp_err, b_req_ready);
      end
    end
  endtask

  task automatic test_reset_mid_comp();
    req_valid = 1'b1;
    req_op    = 1'b1;
    req_addr  = 1'b1;
    req_inb   = {$urandom, $urandom, $urandom, $urandom};
    @(posedge Clk);
    @(negedge Clk);
    req_valid = 1'b0;
    repeat (2) @(negedge Clk);
    checks++;
    if (WL !== {128{1'b1}} || wb !== 1'b1) begin
      errors++;
      $display("FAIL mid_comp wl %h wb %b want all ones 1", WL, wb);
    end
    #2 Rst = 1'b0;
    #1;
    checks++;
    if (pins_now() !== '0 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL async_rst pins %h vld %b rdy %b want 0",
               pins_now(), rsp_valid, req_ready);
    end
    repeat (2) @(negedge Clk);
    Rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      checks++;
      if (rsp_valid !== 1'b0 || pins_now() !== '0 || req_ready !== 1'b1) begin
        errors++;
        $display("FAIL after_rst_%0d vld %b pins %h rdy %b want 0 0 1",
                 i, rsp_valid, pins_now(), req_ready);
      end
    end
    do_req(1'b0, 7'($urandom), junk64(), 1'b0, 128'h0, 64'h0, 1, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_req(1'b0, 7'd17, junk64(), 1'b0, 128'h0, 64'h0, 2, 1'b1);
    do_req(1'b1, 7'd0, 64'h0, 1'b0, {$urandom, $urandom, $urandom, $urandom},
           64'hCAFE_F00D_5555_AAAA, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      do_req(1'($urandom), 7'($urandom), junk64(), 1'($urandom),
             {$urandom, $urandom, $urandom, $urandom}, junk64(),
             int'($urandom_range(0, 3)), 1'($urandom));
    end
  endtask

  initial begin
    req_valid   = 1'b0;
    rsp_ready   = 1'b0;
    scramble_req();
    DOut        = 64'h0;
    b_req_valid = 1'b0;
    b_req_op    = 1'b0;
    b_req_row   = 7'h0;
    b_req_data  = 64'h0;
    b_req_addr  = 1'b0;
    b_req_inb   = 100'h0;
    b_rsp_ready = 1'b0;
    b_DOut      = 64'h0;
    test_reset();
    test_write();
    test_compute();
    test_backpressure();
    test_oor();
    test_reset_mid_comp();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
